// File: rtl/dma_bus_initiator_pkg.sv
// Shared types and constants for the DMA bus initiator: state encodings,
// address step sizes, default bus widths and the memory-map base used by the bench.
package dma_bus_initiator_pkg;

    localparam int DMA_ADDR_W = 16;
    localparam int DMA_DATA_W = 16;
    localparam int DMA_CNT_W  = 16;

    localparam int DMA_INC_BYTE = 1;
    localparam int DMA_INC_WORD = 2;

    localparam logic [15:0] DMA_RAM_BASE = 16'h1C00;

    typedef enum logic [2:0] {
        DMA_IDLE  = 3'd0,
        DMA_REQ   = 3'd1,
        DMA_READ  = 3'd2,
        DMA_WRITE = 3'd3,
        DMA_FIN   = 3'd4
    } dma_state_t;

endpackage

// File: rtl/dma_bus_initiator_if.sv
// System memory bus as seen by one initiator: request/grant plus a single-cycle
// address/data/strobe phase.
interface dma_bus_initiator_if #(
    parameter int ADDR_W = dma_bus_initiator_pkg::DMA_ADDR_W,
    parameter int DATA_W = dma_bus_initiator_pkg::DMA_DATA_W
);
    logic              BUSREQ;
    logic              BUSGNT;
    logic [ADDR_W-1:0] MAB;
    logic [DATA_W-1:0] MDBwrite;
    logic [DATA_W-1:0] MDBread;
    logic              MW;
    logic              BW;

    modport master (output BUSREQ, MAB, MDBwrite, MW, BW, input  BUSGNT, MDBread);
    modport slave  (input  BUSREQ, MAB, MDBwrite, MW, BW, output BUSGNT, MDBread);
endinterface

// File: rtl/dma_bus_initiator_addr_gen.sv
// Loadable address counter stepping +1 (byte) or +2 (word), wrapping modulo 2^ADDR_W.
// Latency: new address visible the cycle after load/step.
// Backpressure: none; advances only when step is asserted.
module dma_bus_initiator_addr_gen
    import dma_bus_initiator_pkg::*;
#(
    parameter int ADDR_W = DMA_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic              byte_mode,
    input  logic [ADDR_W-1:0] start_addr,
    output logic [ADDR_W-1:0] addr
);

    // Word accesses start on an even address; an odd start is truncated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (load) begin
            addr <= byte_mode ? start_addr : {start_addr[ADDR_W-1:1], 1'b0};
        end else if (step) begin
            addr <= addr + (byte_mode ? ADDR_W'(DMA_INC_BYTE) : ADDR_W'(DMA_INC_WORD));
        end
    end

endmodule

// File: rtl/dma_bus_initiator.sv
// Single-channel memory-to-memory copy engine acting as a bus initiator.
// Latency: 2 bus cycles (READ, WRITE) per unit once granted; done/aborted in the FIN cycle.
// Backpressure: waits in REQ for BUSGNT; grant loss during READ retries the read.
module dma_bus_initiator
    import dma_bus_initiator_pkg::*;
#(
    parameter int ADDR_W = DMA_ADDR_W,
    parameter int DATA_W = DMA_DATA_W,
    parameter int CNT_W  = DMA_CNT_W,
    parameter bit BURST  = 1'b1
) (
    input  logic               MCLK,
    input  logic               RST_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  src_addr,
    input  logic [ADDR_W-1:0]  dst_addr,
    input  logic [CNT_W-1:0]   xfer_count,
    input  logic               byte_mode,
    input  logic               src_inc,
    input  logic               dst_inc,
    input  logic               abort,
    dma_bus_initiator_if.master bus,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic [CNT_W-1:0]   remaining
);

    dma_state_t        state_q, state_d;
    logic              byte_q, src_inc_q, dst_inc_q;
    logic              rel_q;
    logic              zero_q;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] src_q, dst_q;
    logic              accept, in_read, in_write, last_unit;

    assign accept    = (state_q == DMA_IDLE) && start && (xfer_count != '0);
    assign in_read   = (state_q == DMA_READ);
    assign in_write  = (state_q == DMA_WRITE);
    assign last_unit = (remaining == CNT_W'(1));

    dma_bus_initiator_addr_gen #(.ADDR_W(ADDR_W)) u_src_gen (
        .clk        (MCLK),
        .rst_n      (RST_n),
        .load       (accept),
        .step       (in_write && src_inc_q),
        .byte_mode  (accept ? byte_mode : byte_q),
        .start_addr (src_addr),
        .addr       (src_q)
    );

    dma_bus_initiator_addr_gen #(.ADDR_W(ADDR_W)) u_dst_gen (
        .clk        (MCLK),
        .rst_n      (RST_n),
        .load       (accept),
        .step       (in_write && dst_inc_q),
        .byte_mode  (accept ? byte_mode : byte_q),
        .start_addr (dst_addr),
        .addr       (dst_q)
    );

    // rel_q holds REQ with BUSREQ low for one cycle so non-burst mode frees the bus between units.
    always_comb begin
        state_d = state_q;
        case (state_q)
            DMA_IDLE:  if (accept) state_d = DMA_REQ;
            DMA_REQ:   if (!rel_q && bus.BUSGNT) state_d = abort ? DMA_FIN : DMA_READ;
            DMA_READ:  state_d = bus.BUSGNT ? DMA_WRITE : DMA_REQ;
            DMA_WRITE: begin
                if (last_unit || abort)     state_d = DMA_FIN;
                else if (BURST && bus.BUSGNT) state_d = DMA_READ;
                else                        state_d = DMA_REQ;
            end
            DMA_FIN:   state_d = DMA_IDLE;
            default:   state_d = DMA_IDLE;
        endcase
    end

    always_ff @(posedge MCLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q   <= DMA_IDLE;
            byte_q    <= 1'b0;
            src_inc_q <= 1'b0;
            dst_inc_q <= 1'b0;
            rel_q     <= 1'b0;
            zero_q    <= 1'b0;
            data_q    <= '0;
            remaining <= '0;
        end else begin
            state_q <= state_d;
            rel_q   <= in_write && !BURST && (state_d == DMA_REQ);
            zero_q  <= (state_q == DMA_IDLE) && start && (xfer_count == '0);
            if (accept) begin
                byte_q    <= byte_mode;
                src_inc_q <= src_inc;
                dst_inc_q <= dst_inc;
                remaining <= xfer_count;
            end else if (in_write) begin
                remaining <= remaining - CNT_W'(1);
            end
            if (in_read && bus.BUSGNT) begin
                data_q <= byte_q ? {{(DATA_W-8){1'b0}}, bus.MDBread[7:0]} : bus.MDBread;
            end
        end
    end

    assign bus.BUSREQ   = ((state_q == DMA_REQ) && !rel_q) || in_read || in_write;
    assign bus.MAB      = in_read ? src_q : (in_write ? dst_q : '0);
    assign bus.MDBwrite = in_write ? data_q : '0;
    assign bus.MW       = in_write;
    assign bus.BW       = (in_read || in_write) && byte_q;

    assign busy    = (state_q != DMA_IDLE);
    assign done    = ((state_q == DMA_FIN) && (remaining == '0)) || zero_q;
    assign aborted = (state_q == DMA_FIN) && (remaining != '0);

endmodule

// File: tb/tb_dma_bus_initiator.sv
// Bench: burst and non-burst initiators share one negedge-clocked block memory;
// a scoreboard of expected writes is filled at each start and drained by the write monitor.
module tb_dma_bus_initiator;
    import dma_bus_initiator_pkg::*;

    localparam logic [15:0] B = DMA_RAM_BASE;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] d;
        logic        bw;
    } wr_t;

    logic        MCLK = 1'b0;
    logic        RST_n;
    logic        start, start_nb;
    logic [15:0] src_addr, dst_addr, xfer_count;
    logic        byte_mode, src_inc, dst_inc, abort;
    logic        gnt, gnt_nb;
    logic [15:0] rdata;
    logic        busy, done, aborted, busy_nb, done_nb, aborted_nb;
    logic [15:0] remaining, remaining_nb;

    logic [15:0] mem [0:32767];
    wr_t         exp_q[$];
    int          checks = 0, failures = 0;
    int          cyc = 0, bus_cyc = 0, wr_total = 0, last_wr_cyc = 0, done_cyc = 0;

    dma_bus_initiator_if bus ();
    dma_bus_initiator_if bus_nb ();
    assign bus.BUSGNT     = gnt;
    assign bus.MDBread    = rdata;
    assign bus_nb.BUSGNT  = gnt_nb;
    assign bus_nb.MDBread = rdata;

    dma_bus_initiator #(.BURST(1'b1)) u_dut (
        .MCLK(MCLK), .RST_n(RST_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .xfer_count(xfer_count), .byte_mode(byte_mode), .src_inc(src_inc), .dst_inc(dst_inc),
        .abort(abort), .bus(bus), .busy(busy), .done(done), .aborted(aborted),
        .remaining(remaining)
    );

    dma_bus_initiator #(.BURST(1'b0)) u_dut_nb (
        .MCLK(MCLK), .RST_n(RST_n), .start(start_nb), .src_addr(src_addr), .dst_addr(dst_addr),
        .xfer_count(xfer_count), .byte_mode(byte_mode), .src_inc(src_inc), .dst_inc(dst_inc),
        .abort(abort), .bus(bus_nb), .busy(busy_nb), .done(done_nb), .aborted(aborted_nb),
        .remaining(remaining_nb)
    );

    always #5 MCLK = ~MCLK;
    always @(posedge MCLK) cyc <= cyc + 1;

    // Idle initiators drive zeros, so OR-ing gives the bus seen by the memory.
    wire [15:0] m_mab = bus.MAB | bus_nb.MAB;
    wire [15:0] m_wd  = bus.MDBwrite | bus_nb.MDBwrite;
    wire        m_mw  = bus.MW | bus_nb.MW;
    wire        m_bw  = bus.BW | bus_nb.BW;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] widx(input logic [15:0] a);
        return a[15:1];
    endfunction

    function automatic logic [15:0] mem_rd(input logic [15:0] a, input logic bw);
        logic [15:0] w;
        w = mem[widx(a)];
        return bw ? {8'h00, (a[0] ? w[15:8] : w[7:0])} : w;
    endfunction

    task automatic mem_wr(input logic [15:0] a, input logic [15:0] d, input logic bw);
        if (!bw)      mem[widx(a)] = d;
        else if (a[0]) mem[widx(a)][15:8] = d[7:0];
        else          mem[widx(a)][7:0] = d[7:0];
    endtask

    always @(negedge MCLK) begin
        if (m_mw) begin
            wr_t e;
            wr_total++;
            last_wr_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexp_wr", 32'(m_mab), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(m_mab), 32'(e.a));
                check("wr_data", 32'(m_wd), 32'(e.d));
                check("wr_bw", 32'(m_bw), 32'(e.bw));
            end
            mem_wr(m_mab, m_wd, m_bw);
        end
        if (m_mw || m_mab != 16'h0000) bus_cyc++;
        rdata <= mem_rd(m_mab, m_bw);
    end

    task automatic expect_copy(input logic [15:0] s, input logic [15:0] d, input bit bm,
                               input bit si, input bit di, input int units);
        logic [15:0] sa, da, step;
        wr_t e;
        sa   = bm ? s : {s[15:1], 1'b0};
        da   = bm ? d : {d[15:1], 1'b0};
        step = bm ? 16'd1 : 16'd2;
        for (int i = 0; i < units; i++) begin
            e.a = da; e.d = mem_rd(sa, bm); e.bw = bm;
            exp_q.push_back(e);
            if (si) sa = sa + step;
            if (di) da = da + step;
        end
    endtask

    task automatic kick(input bit nb, input logic [15:0] s, input logic [15:0] d,
                        input logic [15:0] c, input bit bm, input bit si, input bit di);
        @(negedge MCLK);
        src_addr = s; dst_addr = d; xfer_count = c;
        byte_mode = bm; src_inc = si; dst_inc = di;
        if (nb) start_nb = 1'b1; else start = 1'b1;
        @(negedge MCLK);
        start = 1'b0; start_nb = 1'b0;
    endtask

    task automatic wait_end(output bit gd, output bit ga, output logic [15:0] rem);
        gd = 1'b0; ga = 1'b0; rem = 16'hFFFF;
        for (int i = 0; i < 200; i++) begin
            @(negedge MCLK);
            if (done || aborted) begin
                gd = done; ga = aborted; rem = remaining; done_cyc = cyc;
                return;
            end
        end
        check("end_timeout", 0, 1);
    endtask

    initial begin
        bit          gd, ga, fin, dropped, seen;
        logic [15:0] rem;
        int          n, wr0, cyc0, gaps, drop_cnt;
        logic [15:0] rd_log[$];

        RST_n = 1'b0; start = 1'b0; start_nb = 1'b0; abort = 1'b0;
        src_addr = '0; dst_addr = '0; xfer_count = '0;
        byte_mode = 1'b0; src_inc = 1'b0; dst_inc = 1'b0;
        gnt = 1'b1; gnt_nb = 1'b1;
        for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
        for (int i = 0; i < 24; i++) mem[widx(B + 16'(2 * i))] = 16'(16'hA000 + i * 16'h0123);

        repeat (3) @(negedge MCLK);
        check("rst_busreq", 32'(bus.BUSREQ), 0);
        check("rst_mab", 32'(bus.MAB), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_rem", 32'(remaining), 0);
        @(negedge MCLK);
        RST_n = 1'b1;

        // Word copy, burst, grant held
        wr0 = wr_total; cyc0 = bus_cyc;
        expect_copy(B, B + 16'h40, 1'b0, 1'b1, 1'b1, 4);
        kick(1'b0, B, B + 16'h40, 16'd4, 1'b0, 1'b1, 1'b1);
        wait_end(gd, ga, rem);
        check("t1_done", 32'(gd), 1);
        check("t1_aborted", 32'(ga), 0);
        check("t1_rem", 32'(rem), 0);
        check("t1_bus_cycles", bus_cyc - cyc0, 8);
        check("t1_done_lat", done_cyc - last_wr_cyc, 1);
        check("t1_writes", wr_total - wr0, 4);
        check("t1_ram_last", 32'(mem[widx(B + 16'h46)]), 32'hA369);
        check("t1_sb_empty", exp_q.size(), 0);

        // Byte fill from a fixed odd source
        mem[widx(B)] = 16'hA53C;
        mem[widx(B + 16'h10)] = 16'h0000;
        mem[widx(B + 16'h12)] = 16'hBEEF;
        expect_copy(B + 16'h1, B + 16'h10, 1'b1, 1'b0, 1'b1, 3);
        kick(1'b0, B + 16'h1, B + 16'h10, 16'd3, 1'b1, 1'b0, 1'b1);
        wait_end(gd, ga, rem);
        check("t2_done", 32'(gd), 1);
        check("t2_word10", 32'(mem[widx(B + 16'h10)]), 32'hA5A5);
        check("t2_word12", 32'(mem[widx(B + 16'h12)]), 32'hBEA5);
        check("t2_sb_empty", exp_q.size(), 0);

        // Non-burst, grant dropped for 2 cycles during the first READ
        expect_copy(B, B + 16'hC0, 1'b0, 1'b1, 1'b1, 2);
        kick(1'b1, B, B + 16'hC0, 16'd2, 1'b0, 1'b1, 1'b1);
        fin = 1'b0; dropped = 1'b0; drop_cnt = 0; gaps = 0; gd = 1'b0;
        for (int i = 0; i < 100 && !fin; i++) begin
            @(negedge MCLK);
            if (drop_cnt > 0) begin
                drop_cnt--;
                if (drop_cnt == 0) gnt_nb = 1'b1;
            end
            if (bus_nb.BUSREQ && !bus_nb.MW && bus_nb.MAB != 16'h0000) begin
                rd_log.push_back(bus_nb.MAB);
                if (!dropped) begin
                    gnt_nb = 1'b0; dropped = 1'b1; drop_cnt = 2;
                end
            end
            if (busy_nb && !bus_nb.BUSREQ) gaps++;
            if (done_nb || aborted_nb) begin
                fin = 1'b1; gd = done_nb;
            end
        end
        check("t3_finished", 32'(fin), 1);
        check("t3_done", 32'(gd), 1);
        check("t3_reads", rd_log.size(), 3);
        if (rd_log.size() == 3) begin
            check("t3_read0", 32'(rd_log[0]), 32'(B));
            check("t3_reissue", 32'(rd_log[1]), 32'(B));
            check("t3_read2", 32'(rd_log[2]), 32'(B + 16'h2));
        end
        check("t3_req_gap", 32'(gaps >= 2), 1);
        check("t3_ram", 32'(mem[widx(B + 16'hC2)]), 32'hA123);
        check("t3_sb_empty", exp_q.size(), 0);

        // Abort during the WRITE of unit 2 of 5
        wr0 = wr_total;
        expect_copy(B + 16'h20, B + 16'h60, 1'b0, 1'b1, 1'b1, 2);
        kick(1'b0, B + 16'h20, B + 16'h60, 16'd5, 1'b0, 1'b1, 1'b1);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge MCLK);
            if (bus.MW) n++;
            if (n == 2) begin
                abort = 1'b1;
                break;
            end
        end
        wait_end(gd, ga, rem);
        check("t4_aborted", 32'(ga), 1);
        check("t4_no_done", 32'(gd), 0);
        check("t4_rem", 32'(rem), 3);
        abort = 1'b0;
        repeat (4) @(negedge MCLK);
        check("t4_writes", wr_total - wr0, 2);
        check("t4_bus_idle", 32'({bus.BUSREQ, bus.MW, bus.BW, bus.MAB}), 0);
        check("t4_busy", 32'(busy), 0);
        check("t4_sb_empty", exp_q.size(), 0);

        // Zero-length start, then a start while busy
        kick(1'b0, B, B + 16'h80, 16'd0, 1'b0, 1'b1, 1'b1);
        check("t5_zero_done", 32'(done), 1);
        check("t5_zero_busy", 32'(busy), 0);
        check("t5_zero_req", 32'(bus.BUSREQ), 0);
        @(negedge MCLK);
        check("t5_zero_pulse", 32'(done), 0);
        check("t5_zero_req2", 32'(bus.BUSREQ), 0);
        wr0 = wr_total;
        expect_copy(B + 16'h2, B + 16'h70, 1'b0, 1'b1, 1'b1, 2);
        kick(1'b0, B + 16'h2, B + 16'h70, 16'd2, 1'b0, 1'b1, 1'b1);
        kick(1'b0, B + 16'h4, B + 16'h90, 16'd3, 1'b0, 1'b1, 1'b1);
        wait_end(gd, ga, rem);
        check("t5_busy_done", 32'(gd), 1);
        check("t5_busy_rem", 32'(rem), 0);
        repeat (3) @(negedge MCLK);
        check("t5_busy_writes", wr_total - wr0, 2);
        check("t5_sb_empty", exp_q.size(), 0);

        // Source address wrap 0xFFFE -> 0x0000
        mem[widx(16'hFFFE)] = 16'h1234;
        mem[0] = 16'h5678;
        expect_copy(16'hFFFE, B + 16'h80, 1'b0, 1'b1, 1'b1, 2);
        kick(1'b0, 16'hFFFE, B + 16'h80, 16'd2, 1'b0, 1'b1, 1'b1);
        wait_end(gd, ga, rem);
        check("t6_done", 32'(gd), 1);
        check("t6_ram0", 32'(mem[widx(B + 16'h80)]), 32'h1234);
        check("t6_ram_wrap", 32'(mem[widx(B + 16'h82)]), 32'h5678);
        check("t6_sb_empty", exp_q.size(), 0);

        // Reset asserted in the middle of a WRITE
        expect_copy(B, B + 16'hA0, 1'b0, 1'b1, 1'b1, 4);
        kick(1'b0, B, B + 16'hA0, 16'd4, 1'b0, 1'b1, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge MCLK);
            if (bus.MW) seen = 1'b1;
        end
        check("t7_write_seen", 32'(seen), 1);
        #1 RST_n = 1'b0;
        #1;
        check("t7_rst_mw", 32'(bus.MW), 0);
        check("t7_rst_mab", 32'(bus.MAB), 0);
        check("t7_rst_wdata", 32'(bus.MDBwrite), 0);
        check("t7_rst_busreq", 32'(bus.BUSREQ), 0);
        check("t7_rst_busy", 32'(busy), 0);
        check("t7_rst_rem", 32'(remaining), 0);
        exp_q.delete();
        wr0 = wr_total;
        @(negedge MCLK);
        RST_n = 1'b1;
        repeat (5) @(negedge MCLK);
        check("t7_no_writes", wr_total - wr0, 0);
        check("t7_idle", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
